chrono_ctrl: RTL and testbench

Single-clock controller that sequences the seconds/minutes/hours time counter. Divides the system clock into a 1 Hz base and emits cascaded one-cycle tick pulses (second, minute, hour) while running. Handles start/stop, clear and manual set of minutes and hours from debounced button pulses. Sits between the button debouncer and the time counter, and keeps mirror counts for carry generation and display.

---
 rtl/chrono_ctrl_if.sv | 29 ++
 rtl/chrono_ctrl.sv | 139 +++++++++++++
 tb/tb_chrono_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/chrono_ctrl_if.sv
// Button-pulse inputs and tick/count outputs between debouncer, chrono_ctrl and the time counter.
// The master side drives the button pulses; the slave side is the controller.
interface chrono_ctrl_if;
    logic       start_stop;
    logic       clear;
    logic       mode;
    logic       inc;
    logic       sec_tick;
    logic       min_tick;
    logic       hour_tick;
    logic       cnt_clear;
    logic       running;
    logic [1:0] state;
    logic [7:0] sec_cnt;
    logic [7:0] min_cnt;
    logic [7:0] hour_cnt;

    modport master (
        output start_stop, clear, mode, inc,
        input  sec_tick, min_tick, hour_tick, cnt_clear, running, state,
        input  sec_cnt, min_cnt, hour_cnt
    );

    modport slave (
        input  start_stop, clear, mode, inc,
        output sec_tick, min_tick, hour_tick, cnt_clear, running, state,
        output sec_cnt, min_cnt, hour_cnt
    );
endinterface

// File: rtl/chrono_ctrl.sv
// Run/stop/set sequencer for the h:m:s time counter: 1 Hz prescaler, cascaded tick pulses
// and mirror counts. Every output comes straight from a register.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// STOP     | idle; prescaler holds its fractional second
// RUN      | prescaler counting; second ticks cascade into min/hour
// SET_MIN  | inc steps minutes (59 -> 0), no carry into hours
// SET_HOUR | inc steps hours (99 -> 0)
module chrono_ctrl #(
    parameter int TICK_DIV = 50_000_000,
    parameter int PRE_W    = 26
) (
    input  logic           clk,
    input  logic           reset,
    chrono_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_STOP     = 2'b00,
        ST_RUN      = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_HOUR = 2'b11
    } state_t;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [7:0]       SEC_MAX  = 8'd59;
    localparam logic [7:0]       MIN_MAX  = 8'd59;
    localparam logic [7:0]       HOUR_MAX = 8'd99;

    state_t           state_q;
    logic             running_q;
    logic [PRE_W-1:0] pre_q;
    logic [7:0]       sec_q;
    logic [7:0]       min_q;
    logic [7:0]       hour_q;
    logic             sec_tick_q;
    logic             min_tick_q;
    logic             hour_tick_q;
    logic             cnt_clear_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_STOP;
            running_q   <= 1'b0;
            pre_q       <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            cnt_clear_q <= 1'b0;
        end else begin
            sec_tick_q  <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            cnt_clear_q <= 1'b0;

            // clear outranks everything and leaves the state alone, even in RUN
            if (bus.clear) begin
                pre_q       <= '0;
                sec_q       <= '0;
                min_q       <= '0;
                hour_q      <= '0;
                cnt_clear_q <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_STOP: begin
                        if (bus.start_stop) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end else if (bus.mode) begin
                            state_q <= ST_SET_MIN;
                        end
                    end

                    ST_RUN: begin
                        // the wrap still fires on the cycle that stops the clock
                        if (pre_q == PRE_LAST) begin
                            pre_q      <= '0;
                            sec_tick_q <= 1'b1;
                            if (sec_q == SEC_MAX) begin
                                sec_q      <= '0;
                                min_tick_q <= 1'b1;
                                if (min_q == MIN_MAX) begin
                                    min_q       <= '0;
                                    hour_tick_q <= 1'b1;
                                    hour_q      <= (hour_q == HOUR_MAX) ? 8'd0 : hour_q + 8'd1;
                                end else begin
                                    min_q <= min_q + 8'd1;
                                end
                            end else begin
                                sec_q <= sec_q + 8'd1;
                            end
                        end else begin
                            pre_q <= pre_q + 1'b1;
                        end
                        if (bus.start_stop) begin
                            state_q   <= ST_STOP;
                            running_q <= 1'b0;
                        end
                    end

                    ST_SET_MIN: begin
                        if (bus.start_stop) begin
                            state_q <= ST_STOP;
                        end else if (bus.mode) begin
                            state_q <= ST_SET_HOUR;
                        end else if (bus.inc) begin
                            min_q      <= (min_q == MIN_MAX) ? 8'd0 : min_q + 8'd1;
                            min_tick_q <= 1'b1;
                        end
                    end

                    ST_SET_HOUR: begin
                        if (bus.start_stop || bus.mode) begin
                            state_q <= ST_STOP;
                        end else if (bus.inc) begin
                            hour_q      <= (hour_q == HOUR_MAX) ? 8'd0 : hour_q + 8'd1;
                            hour_tick_q <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.sec_tick  = sec_tick_q;
    assign bus.min_tick  = min_tick_q;
    assign bus.hour_tick = hour_tick_q;
    assign bus.cnt_clear = cnt_clear_q;
    assign bus.running   = running_q;
    assign bus.state     = state_q;
    assign bus.sec_cnt   = sec_q;
    assign bus.min_cnt   = min_q;
    assign bus.hour_cnt  = hour_q;

endmodule

// File: tb/tb_chrono_ctrl.sv
// Scoreboard bench for chrono_ctrl at TICK_DIV=4: stimulus queues the expected pulse events,
// a negedge monitor pops one for every tick/clear pulse the DUT emits.
module tb_chrono_ctrl;

    localparam logic [3:0] P_SEC  = 4'b1000;
    localparam logic [3:0] P_MIN  = 4'b0100;
    localparam logic [3:0] P_HOUR = 4'b0010;
    localparam logic [3:0] P_CLR  = 4'b0001;
    localparam int B_SS   = 0;
    localparam int B_CLR  = 1;
    localparam int B_MODE = 2;
    localparam int B_INC  = 3;

    typedef struct {
        int         cyc;
        logic [3:0] pulses;
        logic [7:0] s;
        logic [7:0] m;
        logic [7:0] h;
        logic [1:0] st;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];
    exp_t mon_e;

    chrono_ctrl_if bus();

    chrono_ctrl #(.TICK_DIV(4), .PRE_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [3:0] p, input int s, input int m, input int h,
                        input logic [1:0] st);
        exp_t e;
        e.cyc = c; e.pulses = p; e.s = 8'(s); e.m = 8'(m); e.h = 8'(h); e.st = st;
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            B_SS:    bus.start_stop = 1'b1;
            B_CLR:   bus.clear      = 1'b1;
            B_MODE:  bus.mode       = 1'b1;
            default: bus.inc        = 1'b1;
        endcase
        @(negedge clk);
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.mode       = 1'b0;
        bus.inc        = 1'b0;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && (bus.sec_tick || bus.min_tick || bus.hour_tick || bus.cnt_clear)) begin
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got pulses=%b s/m/h=%0d/%0d/%0d at cyc %0d, expected none",
                         {bus.sec_tick, bus.min_tick, bus.hour_tick, bus.cnt_clear},
                         bus.sec_cnt, bus.min_cnt, bus.hour_cnt, cyc);
            end else begin
                mon_e = q.pop_front();
                if (cyc != mon_e.cyc
                    || {bus.sec_tick, bus.min_tick, bus.hour_tick, bus.cnt_clear} != mon_e.pulses
                    || bus.sec_cnt != mon_e.s || bus.min_cnt != mon_e.m || bus.hour_cnt != mon_e.h
                    || bus.state != mon_e.st) begin
                    n_errors++;
                    $display("FAIL pulse_event: got cyc=%0d pulses=%b s/m/h=%0d/%0d/%0d st=%0d, expected cyc=%0d pulses=%b s/m/h=%0d/%0d/%0d st=%0d",
                             cyc, {bus.sec_tick, bus.min_tick, bus.hour_tick, bus.cnt_clear},
                             bus.sec_cnt, bus.min_cnt, bus.hour_cnt, bus.state,
                             mon_e.cyc, mon_e.pulses, mon_e.s, mon_e.m, mon_e.h, mon_e.st);
                end
            end
        end
    end

    initial begin
        int e, r, c, s, u;
        bus.start_stop = 1'b0;
        bus.clear      = 1'b0;
        bus.mode       = 1'b0;
        bus.inc        = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_state", int'(bus.state), 0);
        chk("rst_running", int'(bus.running), 0);
        chk("rst_counts", int'({bus.sec_cnt, bus.min_cnt, bus.hour_cnt}), 0);
        chk("rst_pulses", int'({bus.sec_tick, bus.min_tick, bus.hour_tick, bus.cnt_clear}), 0);
        reset = 1'b0;
        @(negedge clk);

        // set mode walk: inc ignored in STOP, minutes wrap, hours go round once
        pulse(B_INC);
        pulse(B_MODE);
        chk("state_set_min", int'(bus.state), 2);
        for (int i = 1; i <= 61; i++) begin
            push(cyc + 1, P_MIN, 0, i % 60, 0, 2'd2);
            pulse(B_INC);
        end
        chk("min_after_61", int'(bus.min_cnt), 1);
        pulse(B_MODE);
        chk("state_set_hour", int'(bus.state), 3);
        for (int i = 1; i <= 100; i++) begin
            push(cyc + 1, P_HOUR, 0, 1, i % 100, 2'd3);
            pulse(B_INC);
        end
        chk("hour_after_100", int'(bus.hour_cnt), 0);
        for (int i = 1; i <= 5; i++) begin
            push(cyc + 1, P_HOUR, 0, 1, i, 2'd3);
            pulse(B_INC);
        end
        pulse(B_MODE);
        chk("state_back_stop", int'(bus.state), 0);
        pulse(B_MODE);
        for (int i = 1; i <= 58; i++) begin
            push(cyc + 1, P_MIN, 0, 1 + i, 5, 2'd2);
            pulse(B_INC);
        end
        pulse(B_MODE);
        pulse(B_MODE);
        chk("preset_state", int'(bus.state), 0);
        chk("preset_min", int'(bus.min_cnt), 59);
        chk("preset_hour", int'(bus.hour_cnt), 5);

        // run through 59 seconds then the full sec/min/hour cascade
        e = cyc + 1;
        for (int k = 1; k <= 59; k++) push(e + 4 * k, P_SEC, k, 59, 5, 2'd1);
        push(e + 240, P_SEC | P_MIN | P_HOUR, 0, 0, 6, 2'd1);
        pulse(B_SS);
        chk("run_running", int'(bus.running), 1);
        chk("run_state", int'(bus.state), 1);
        wait_until(e + 10);
        pulse(B_MODE);
        pulse(B_INC);
        chk("run_ignores_mode", int'(bus.state), 1);

        // pause with prescaler at 2, resume: next tick 2 cycles later
        wait_until(e + 241);
        pulse(B_SS);
        chk("pause_running", int'(bus.running), 0);
        chk("pause_state", int'(bus.state), 0);
        wait_until(e + 252);
        r = cyc + 1;
        push(r + 2, P_SEC, 1, 0, 6, 2'd1);
        push(r + 6, P_SEC, 2, 0, 6, 2'd1);
        pulse(B_SS);

        // clear + start_stop together on a would-be wrap cycle
        wait_until(r + 9);
        c = cyc + 1;
        push(c, P_CLR, 0, 0, 0, 2'd1);
        bus.clear      = 1'b1;
        bus.start_stop = 1'b1;
        @(negedge clk);
        bus.clear      = 1'b0;
        bus.start_stop = 1'b0;
        chk("clear_keeps_run", int'(bus.state), 1);
        chk("clear_counts", int'({bus.sec_cnt, bus.min_cnt, bus.hour_cnt}), 0);

        // stop on the wrap cycle: tick still issued, state goes STOP
        push(c + 4, P_SEC, 1, 0, 0, 2'd0);
        wait_until(c + 3);
        pulse(B_SS);
        chk("wrap_stop_state", int'(bus.state), 0);
        wait_until(c + 12);

        // asynchronous reset in the middle of RUN
        s = cyc + 1;
        push(s + 4, P_SEC, 2, 0, 0, 2'd1);
        pulse(B_SS);
        wait_until(s + 5);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_running", int'(bus.running), 0);
        chk("async_rst_state", int'(bus.state), 0);
        chk("async_rst_counts", int'({bus.sec_cnt, bus.min_cnt, bus.hour_cnt}), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_state", int'(bus.state), 0);
        u = cyc + 1;
        push(u + 4, P_SEC, 1, 0, 0, 2'd1);
        pulse(B_SS);
        wait_until(u + 6);
        chk("pending_events", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
